// File: rtl/stack_queue_buffer.sv
// -----------------------------------------------------------------------------
// stack_queue_buffer
//   Parametrised LIFO/FIFO storage engine. The mode is chosen at run time and
//   is latched only while the buffer is empty. The occupancy count, status
//   flags and sticky error bits are all registered. Read data comes
//   asynchronously from the top entry (LIFO) or the head entry (FIFO).
//
// Ports
//   clk           in   single clock, all state on rising edge
//   reset         in   synchronous, active-low (0 = reset)
//   mode          in   0 = LIFO, 1 = FIFO; taken only while empty
//   push          in   one-cycle write request
//   pop           in   one-cycle read/remove request
//   w_data        in   write data, sampled with push
//   r_data        out  top (LIFO) / head (FIFO) entry, 0 when empty
//   empty         out  data_count == 0
//   full          out  data_count == DEPTH
//   almost_empty  out  data_count <= AE_THRESH
//   almost_full   out  data_count >= AF_THRESH
//   data_count    out  occupancy 0..DEPTH
//   overflow      out  sticky: push refused while full
//   underflow     out  sticky: pop refused while empty
//   clr_err       in   clears overflow/underflow (and high_water, if built)
//   high_water    out  peak data_count (0 unless STACK_HWM_EN)
//
// Build option
//   STACK_HWM_EN  when defined, a high-water-mark register tracks peak
//                 occupancy; otherwise high_water is tied to 0.
// -----------------------------------------------------------------------------
module stack_queue_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   high_water
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH-1:0] head_r;
    logic [ADDR_WIDTH-1:0] tail_r;
    logic                  mode_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  ae_r;
    logic                  af_r;
    logic                  ovf_r;
    logic                  unf_r;

    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [ADDR_WIDTH-1:0] head_nxt_s;
    logic [ADDR_WIDTH-1:0] tail_nxt_s;
    logic                  mode_eff_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic                  is_empty_s;
    logic                  is_full_s;
    logic [ADDR_WIDTH-1:0] top_idx_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;

    // Stack top sits one below the count; at full the low bits wrap to DEPTH-1.
    assign top_idx_s  = count_r[ADDR_WIDTH-1:0] - PTR_ONE;
    assign is_empty_s = (count_r == {(ADDR_WIDTH+1){1'b0}});
    assign is_full_s  = (count_r == DEPTH_C);

    // Operating mode for this edge: an empty buffer adopts the requested mode
    // immediately so a push on that same edge is placed where it will be read.
    assign mode_eff_s = is_empty_s ? mode : mode_r;

    // Next-state decode of count, pointers, memory write and error events.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = {ADDR_WIDTH{1'b0}};
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (is_full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    wr_en_s     = 1'b1;
                    count_nxt_s = count_r + CNT_ONE;
                    if (mode_eff_s) begin
                        wr_addr_s  = tail_r;
                        tail_nxt_s = tail_r + PTR_ONE;
                    end else begin
                        wr_addr_s = count_r[ADDR_WIDTH-1:0];
                    end
                end
            end
            2'b01: begin
                if (is_empty_s) begin
                    unf_set_s = 1'b1;
                end else begin
                    count_nxt_s = count_r - CNT_ONE;
                    if (mode_eff_s) begin
                        head_nxt_s = head_r + PTR_ONE;
                    end else begin
                        head_nxt_s = head_r;
                    end
                end
            end
            2'b11: begin
                wr_en_s = 1'b1;
                if (is_empty_s) begin
                    // Nothing to pop: behaves as a plain push.
                    count_nxt_s = count_r + CNT_ONE;
                    if (mode_eff_s) begin
                        wr_addr_s  = tail_r;
                        tail_nxt_s = tail_r + PTR_ONE;
                    end else begin
                        wr_addr_s = count_r[ADDR_WIDTH-1:0];
                    end
                end else if (mode_eff_s) begin
                    // Queue: enqueue at tail and dequeue at head together.
                    wr_addr_s  = tail_r;
                    tail_nxt_s = tail_r + PTR_ONE;
                    head_nxt_s = head_r + PTR_ONE;
                end else begin
                    // Stack: overwrite the current top in place.
                    wr_addr_s = top_idx_s;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Control state, registered flags and sticky error bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {(ADDR_WIDTH+1){1'b0}};
            head_r  <= {ADDR_WIDTH{1'b0}};
            tail_r  <= {ADDR_WIDTH{1'b0}};
            mode_r  <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ae_r    <= 1'b1;
            af_r    <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            mode_r  <= mode_eff_s;
            empty_r <= (count_nxt_s == {(ADDR_WIDTH+1){1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
            ae_r    <= (count_nxt_s <= AE_C);
            af_r    <= (count_nxt_s >= AF_C);
            // Clear wins over a same-edge error event.
            ovf_r   <= clr_err ? 1'b0 : (ovf_r | ovf_set_s);
            unf_r   <= clr_err ? 1'b0 : (unf_r | unf_set_s);
        end
    end

    // Storage array; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (reset && wr_en_s) begin
            mem_r[wr_addr_s] <= w_data;
        end
    end

`ifdef STACK_HWM_EN
    logic [ADDR_WIDTH:0] hwm_r;

    // Peak occupancy tracker, cleared by reset or clr_err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hwm_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (clr_err) begin
            hwm_r <= {(ADDR_WIDTH+1){1'b0}};
        end else if (count_nxt_s > hwm_r) begin
            hwm_r <= count_nxt_s;
        end else begin
            hwm_r <= hwm_r;
        end
    end

    assign high_water = hwm_r;
`else
    assign high_water = {(ADDR_WIDTH+1){1'b0}};
`endif

    assign rd_idx_s     = mode_r ? head_r : top_idx_s;
    assign r_data       = empty_r ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx_s];
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;
    assign data_count   = count_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_stack_queue_buffer.sv
// -----------------------------------------------------------------------------
// tb_stack_queue_buffer
//   Self-checking bench for stack_queue_buffer (default parameters). A
//   queue-based reference model produces the expected outputs for every
//   driven cycle; they are queued as a scoreboard and compared one edge later.
//   A small constant vector table and hand-written sequences cover the
//   documented corner cases.
// -----------------------------------------------------------------------------
module tb_stack_queue_buffer;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       push;
    logic       pop;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] data_count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;
    logic [4:0] high_water;

    stack_queue_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .push         (push),
        .pop          (pop),
        .w_data       (w_data),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err),
        .high_water   (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r_data;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       unf;
        logic [4:0] hwm;
    } exp_t;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] wd;
        logic [7:0] exp_r;
        logic [4:0] exp_c;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[5];

    // Reference model state
    logic [7:0] mq[$];
    logic       m_mode;
    logic       m_ovf;
    logic       m_unf;
    int         m_hwm;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_apply(input logic rst_i, input logic md, input logic ps,
                                        input logic pp, input logic clr, input logic [7:0] wd);
        int   n;
        logic eff;
        logic ovf_ev;
        logic unf_ev;
        exp_t e;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (!rst_i) begin
            mq.delete();
            m_mode = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_hwm  = 0;
        end else begin
            n   = mq.size();
            eff = (n == 0) ? md : m_mode;
            m_mode = eff;
            if (ps && pp) begin
                if (n == 0) mq.push_back(wd);
                else if (!eff) mq[n-1] = wd;
                else begin
                    void'(mq.pop_front());
                    mq.push_back(wd);
                end
            end else if (ps) begin
                if (n == DEPTH) ovf_ev = 1'b1;
                else mq.push_back(wd);
            end else if (pp) begin
                if (n == 0) unf_ev = 1'b1;
                else if (!eff) void'(mq.pop_back());
                else void'(mq.pop_front());
            end
            m_ovf = clr ? 1'b0 : (m_ovf | ovf_ev);
            m_unf = clr ? 1'b0 : (m_unf | unf_ev);
            if (clr) m_hwm = 0;
            else if (mq.size() > m_hwm) m_hwm = mq.size();
        end
        n       = mq.size();
        e.count = 5'(n);
        e.r_data = (n == 0) ? 8'h00 : (m_mode ? mq[0] : mq[n-1]);
        e.empty = (n == 0);
        e.full  = (n == DEPTH);
        e.ae    = (n <= 1);
        e.af    = (n >= DEPTH - 1);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
`ifdef STACK_HWM_EN
        e.hwm   = 5'(m_hwm);
`else
        e.hwm   = 5'd0;
`endif
        exp_q.push_back(e);
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            chk("r_data", 32'(r_data), 32'(e.r_data));
            chk("data_count", 32'(data_count), 32'(e.count));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("full", 32'(full), 32'(e.full));
            chk("almost_empty", 32'(almost_empty), 32'(e.ae));
            chk("almost_full", 32'(almost_full), 32'(e.af));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
            chk("high_water", 32'(high_water), 32'(e.hwm));
        end
    endtask

    // One clock: drive at negedge, queue the expectation, compare after posedge.
    task automatic step(input logic rst_i, input logic md, input logic ps,
                        input logic pp, input logic clr, input logic [7:0] wd);
        @(negedge clk);
        reset   = rst_i;
        mode    = md;
        push    = ps;
        pop     = pp;
        clr_err = clr;
        w_data  = wd;
        model_apply(rst_i, md, ps, pp, clr, wd);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; w_data = 8'h00;

        vt[0] = '{push: 1'b1, pop: 1'b0, wd: 8'h11, exp_r: 8'h11, exp_c: 5'd1};
        vt[1] = '{push: 1'b1, pop: 1'b0, wd: 8'h22, exp_r: 8'h22, exp_c: 5'd2};
        vt[2] = '{push: 1'b1, pop: 1'b0, wd: 8'h33, exp_r: 8'h33, exp_c: 5'd3};
        vt[3] = '{push: 1'b0, pop: 1'b1, wd: 8'h00, exp_r: 8'h22, exp_c: 5'd2};
        vt[4] = '{push: 1'b1, pop: 1'b1, wd: 8'h44, exp_r: 8'h44, exp_c: 5'd2};

        // Power-up reset, then a mid-fill reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
        chk("fill5_count", 32'(data_count), 32'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_errs", 32'({overflow, underflow}), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'd0);

        // LIFO table
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, vt[i].push, vt[i].pop, 1'b0, vt[i].wd);
            chk("vec_rdata", 32'(r_data), 32'(vt[i].exp_r));
            chk("vec_count", 32'(data_count), 32'(vt[i].exp_c));
        end
        while (mq.size() > 0) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // FIFO, latched while empty, then alternation across pointer wrap
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fifo_head", 32'(r_data), 32'h22);
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 7) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom_range(255)));
            else if (i % 2 == 0) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(255)));
            else step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        while (mq.size() > 0) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Fill to full in LIFO mode
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
            if (i == 13) chk("af_at14", 32'(almost_full), 32'd0);
            if (i == 14) chk("af_at15", 32'({almost_full, full}), 32'b10);
        end
        chk("full_at16", 32'({almost_full, full}), 32'b11);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("pp_full_count", 32'(data_count), 32'd16);
        chk("pp_full_noerr", 32'(overflow), 32'd0);
        chk("pp_full_top", 32'(r_data), 32'hEE);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(data_count), 32'd16);

        // Drain, underflow, clear
        while (mq.size() > 0) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_count", 32'(data_count), 32'd0);
`ifdef STACK_HWM_EN
        chk("hwm_peak", 32'(high_water), 32'd16);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("clr_errs", 32'({overflow, underflow}), 32'd0);
        chk("clr_hwm", 32'(high_water), 32'd0);

        // Mode change while non-empty is ignored
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        chk("nomode_top", 32'(r_data), 32'hC3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("nomode_pop", 32'(r_data), 32'hC2);
        while (mq.size() > 0) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD2);
        chk("newmode_head", 32'(r_data), 32'hD1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("newmode_pop", 32'(r_data), 32'hD2);

        @(negedge clk);
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
